upp_rx_deframer: RTL and testbench
==================================

Name: upp_rx_deframer

Overview:
- Consumes the 32-bit word stream leaving the DSP-receive UPP port (data_out/data_valid, read side of the 32x256 FIFO, clk_20m domain).
- Hunts for a sync word, parses a header, forwards payload words with frame markers, and checks a 32-bit additive checksum.
- Reports per-frame status and error counters to the top level.
- No backpressure: the upstream FIFO drains continuously, so every input word is accepted in the cycle it is valid.

Parameters:
SYNC_WORD, 32'hEB90_146F, frame delimiter word.
MAX_LEN, 64, largest legal payload length in words (1..65535).
TIMEOUT, 1023, idle clk_20m cycles tolerated mid-frame before abort (10-bit counter).

Ports:
clk_20m  input  1  clock; same clock as the UPP receive FIFO read side.
cfg_rst_n  input  1  reset, asynchronous, active-low.
in_data  input  32  word from upp_io data_out, {Q[15:0], I[15:0]}.
in_valid  input  1  word valid (upp_io data_valid).
pay_data  output  32  payload word.
pay_valid  output  1  payload word strobe.
pay_sof  output  1  first payload word of frame, qualified by pay_valid.
pay_eof  output  1  last payload word of frame, qualified by pay_valid.
pay_type  output  8  type field of current frame; held until next header.
frame_done  output  1  one-cycle pulse at frame end or abort.
frame_ok  output  1  qualified by frame_done: 1 = good frame.
err_code  output  3  qualified by frame_done: 0 none, 1 length, 2 checksum, 3 sequence, 4 timeout.
ok_cnt  output  16  good-frame count, saturating at 16'hFFFF.
err_cnt  output  16  bad-frame count, saturating at 16'hFFFF.

Behaviour:
- Reset: every output is 0; state = HUNT; checksum accumulator, idle counter and word counter cleared.
- Frame format: SYNC_WORD, header {type[31:24], seq[23:16], len[15:0]}, len payload words, checksum word.
- Checksum word must equal (header + all payload words) mod 2^32.
- All outputs are registered; latency is exactly 1 cycle from the input word to the resulting output.
- State HUNT: any in_valid word other than SYNC_WORD is discarded; SYNC_WORD moves to HDR.
- State HDR: on the next valid word, latch type/seq/len and load the accumulator with the header.
  - If len > MAX_LEN: frame_done=1, err_code=1, err_cnt+1, return to HUNT.
  - If len = 0: go to CKSUM.
  - Otherwise: go to PAYLOAD.
- State PAYLOAD: each valid word is emitted on pay_data with pay_valid=1 and added to the accumulator.
  - pay_sof is set on the first word; pay_eof on word len. Both are set on the same beat when len = 1.
  - After word len, go to CKSUM.
- SYNC_WORD values appearing inside PAYLOAD or CKSUM are treated as ordinary data; there is no resync.
- State CKSUM: on the next valid word, frame_done=1.
  - On mismatch: err_code=2.
  - Otherwise, on sequence error (feature enabled): err_code=3.
  - Otherwise: frame_ok=1.
  - Increment the matching counter; return to HUNT.
  - Checksum error takes priority over sequence error.
- Timeout: in HDR/PAYLOAD/CKSUM the idle counter increments on each cycle with in_valid=0 and clears on in_valid=1.
  - When it reaches TIMEOUT: frame_done=1, err_code=4, err_cnt+1, return to HUNT.
  - No pay_eof is generated on timeout; downstream discards a partial frame on frame_done with frame_ok=0.
- Gaps in in_valid shorter than TIMEOUT are legal anywhere; outputs simply stall.
- Counters saturate and never wrap.
- Asserting reset mid-frame clears everything immediately; no frame_done is issued.

Optional Feature:
UPP_SEQ_CHECK_EN
- Defined:
  - Track expected_seq. The first frame after reset is accepted with any seq.
  - Each following header must carry expected_seq; 8'hFF wraps to 8'h00.
  - A mismatch flags err_code=3 at CKSUM; payload is still forwarded.
  - expected_seq is reloaded with received seq+1 after every header, whether or not it matched.
- Undefined: no sequence state is built; err_code 3 never occurs.

Test Plan:
- Good frame: idle noise 32'h1234_5678, then EB90146F, header 32'h0501_0003, payload 1,2,3, checksum 32'h0501_0009.
  - Expect 3 pay_valid beats with sof on 1 and eof on 3, pay_type=8'h05.
  - Expect frame_done with frame_ok=1 one cycle after the checksum word; ok_cnt=1.
- Same frame with checksum 32'h0501_0008 -> payload still forwarded; frame_done, err_code=2, err_cnt=1.
- Zero length then oversize:
  - Header 32'h0002_0000, checksum 32'h0002_0000 -> no pay_valid; frame_ok=1.
  - Header len=65 (MAX_LEN=64) -> frame_done, err_code=1, one cycle after the header.
- Timeout: sync, header len=4, 2 payload words, then in_valid low for 1023 cycles.
  - Expect frame_done, err_code=4, with no pay_eof.
  - A following good frame is parsed correctly.
- Back-to-back and gapped traffic: two good frames with no idle between them, then one with a random 0-20 cycle in_valid gap between words.
  - All three frames give frame_ok=1; a payload word equal to SYNC_WORD is forwarded as data.
- With UPP_SEQ_CHECK_EN defined, send seq 8'hFE, 8'hFF, 8'h00, 8'h02.
  - First three frames ok; fourth gives err_code=3, ok_cnt=3, err_cnt=1.
  - A 5th frame with seq 8'h03 -> ok.

Source files
------------

// File: rtl/upp_rx_deframer.sv
// Purpose : deframes the UPP receive word stream (sync, header, payload, additive checksum).
// Latency : 1 clk_20m cycle from an accepted input word to every output it affects.
// Backpres: none; every in_valid word is consumed in the cycle it is presented.
//
// Ports:
//   clk_20m, cfg_rst_n        clock and async active-low reset
//   in_data/in_valid          word stream from the UPP receive FIFO read side
//   pay_data/pay_valid        forwarded payload words, pay_sof/pay_eof mark frame bounds
//   pay_type                  type field of the most recent header
//   frame_done/frame_ok       end-of-frame (or abort) pulse and its good/bad flag
//   err_code                  0 none, 1 length, 2 checksum, 3 sequence, 4 timeout
//   ok_cnt/err_cnt            saturating good/bad frame counters
// Optional feature macro: UPP_SEQ_CHECK_EN enables header sequence-number checking.
module upp_rx_deframer #(
   parameter logic [31:0] SYNC_WORD = 32'hEB90_146F,
   parameter int          MAX_LEN   = 64,
   parameter int          TIMEOUT   = 1023
) (
   input  logic        clk_20m,
   input  logic        cfg_rst_n,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic [31:0] pay_data,
   output logic        pay_valid,
   output logic        pay_sof,
   output logic        pay_eof,
   output logic [7:0]  pay_type,
   output logic        frame_done,
   output logic        frame_ok,
   output logic [2:0]  err_code,
   output logic [15:0] ok_cnt,
   output logic [15:0] err_cnt
);

   typedef enum logic [1:0] {HUNT, HDR, PAYLOAD, CKSUM} state_t;

   localparam logic [9:0]  TIMEOUT_M1 = 10'(TIMEOUT - 1);
   localparam logic [15:0] MAX_LEN_W  = 16'(MAX_LEN);

   localparam logic [2:0] ERR_NONE = 3'd0;
   localparam logic [2:0] ERR_LEN  = 3'd1;
   localparam logic [2:0] ERR_CSUM = 3'd2;
   localparam logic [2:0] ERR_SEQ  = 3'd3;
   localparam logic [2:0] ERR_TOUT = 3'd4;

   state_t      state;
   logic [31:0] acc;
   logic [15:0] len;
   logic [15:0] word_cnt;
   logic [9:0]  idle_cnt;
   logic        idle_hit;
   logic        seq_flag;

`ifdef UPP_SEQ_CHECK_EN
   logic [7:0] expected_seq;
   logic       seq_seen;   // first header after reset is accepted with any seq
   logic       seq_err;
   assign seq_flag = seq_err;
`else
   assign seq_flag = 1'b0;
`endif

   // The abort fires on the idle cycle that brings the count to TIMEOUT.
   assign idle_hit = (state != HUNT) && !in_valid && (idle_cnt == TIMEOUT_M1);

   always_ff @(posedge clk_20m or negedge cfg_rst_n) begin
      if (!cfg_rst_n) begin
         state      <= HUNT;
         acc        <= '0;
         len        <= '0;
         word_cnt   <= '0;
         idle_cnt   <= '0;
         pay_data   <= '0;
         pay_valid  <= 1'b0;
         pay_sof    <= 1'b0;
         pay_eof    <= 1'b0;
         pay_type   <= '0;
         frame_done <= 1'b0;
         frame_ok   <= 1'b0;
         err_code   <= ERR_NONE;
         ok_cnt     <= '0;
         err_cnt    <= '0;
`ifdef UPP_SEQ_CHECK_EN
         expected_seq <= '0;
         seq_seen     <= 1'b0;
         seq_err      <= 1'b0;
`endif
      end else begin
         // strobes are single-cycle by default
         pay_valid  <= 1'b0;
         pay_sof    <= 1'b0;
         pay_eof    <= 1'b0;
         frame_done <= 1'b0;
         frame_ok   <= 1'b0;
         err_code   <= ERR_NONE;

         if (state == HUNT)
            idle_cnt <= '0;
         else if (in_valid)
            idle_cnt <= '0;
         else
            idle_cnt <= idle_cnt + 10'd1;

         if (idle_hit) begin
            frame_done <= 1'b1;
            err_code   <= ERR_TOUT;
            err_cnt    <= (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;
            idle_cnt   <= '0;
            state      <= HUNT;
         end else if (in_valid) begin
            case (state)
               HUNT: begin
                  if (in_data == SYNC_WORD)
                     state <= HDR;
               end
               HDR: begin
                  pay_type <= in_data[31:24];
                  len      <= in_data[15:0];
                  acc      <= in_data;
                  word_cnt <= '0;
`ifdef UPP_SEQ_CHECK_EN
                  seq_err      <= seq_seen && (in_data[23:16] != expected_seq);
                  expected_seq <= in_data[23:16] + 8'd1;
                  seq_seen     <= 1'b1;
`endif
                  if (in_data[15:0] > MAX_LEN_W) begin
                     frame_done <= 1'b1;
                     err_code   <= ERR_LEN;
                     err_cnt    <= (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;
                     state      <= HUNT;
                  end else if (in_data[15:0] == 16'd0) begin
                     state <= CKSUM;
                  end else begin
                     state <= PAYLOAD;
                  end
               end
               PAYLOAD: begin
                  // sync-word values here are plain data: no resync
                  pay_data  <= in_data;
                  pay_valid <= 1'b1;
                  pay_sof   <= (word_cnt == 16'd0);
                  acc       <= acc + in_data;
                  word_cnt  <= word_cnt + 16'd1;
                  if (word_cnt + 16'd1 == len) begin
                     pay_eof <= 1'b1;
                     state   <= CKSUM;
                  end
               end
               CKSUM: begin
                  frame_done <= 1'b1;
                  if (in_data != acc) begin
                     err_code <= ERR_CSUM;
                     err_cnt  <= (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;
                  end else if (seq_flag) begin
                     err_code <= ERR_SEQ;
                     err_cnt  <= (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;
                  end else begin
                     frame_ok <= 1'b1;
                     ok_cnt   <= (ok_cnt == 16'hFFFF) ? ok_cnt : ok_cnt + 16'd1;
                  end
                  state <= HUNT;
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_upp_rx_deframer.sv
// Purpose : directed self-checking bench for upp_rx_deframer.
// Latency : outputs are checked #1 after the edge that sampled the input word.
// Backpres: none; the bench drives words whenever it likes, with optional gaps.
module tb_upp_rx_deframer;

   localparam logic [31:0] SYNC = 32'hEB90_146F;

   logic        clk_20m = 1'b0;
   logic        cfg_rst_n = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic [31:0] pay_data;
   logic        pay_valid, pay_sof, pay_eof;
   logic [7:0]  pay_type;
   logic        frame_done, frame_ok;
   logic [2:0]  err_code;
   logic [15:0] ok_cnt, err_cnt;

   int checks = 0;
   int errors = 0;
   int exp_ok = 0;
   int exp_err = 0;
   logic [31:0] pl[$];

   upp_rx_deframer dut (
      .clk_20m(clk_20m), .cfg_rst_n(cfg_rst_n),
      .in_data(in_data), .in_valid(in_valid),
      .pay_data(pay_data), .pay_valid(pay_valid),
      .pay_sof(pay_sof), .pay_eof(pay_eof), .pay_type(pay_type),
      .frame_done(frame_done), .frame_ok(frame_ok), .err_code(err_code),
      .ok_cnt(ok_cnt), .err_cnt(err_cnt)
   );

   always #25 clk_20m = ~clk_20m;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // drive one word for one cycle; returns #1 after the sampling edge
   task automatic send(input logic [31:0] w);
      in_valid = 1'b1;
      in_data  = w;
      @(posedge clk_20m);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_20m);
         #1;
      end
   endtask

   task automatic gap(input int gap_max);
      if (gap_max > 0) idle($urandom_range(0, gap_max));
   endtask

   task automatic chk_counters(input string tag);
      chk_val({tag, "_okcnt"}, 32'(ok_cnt), 32'(exp_ok));
      chk_val({tag, "_errcnt"}, 32'(err_cnt), 32'(exp_err));
   endtask

   // full frame: sync, header, words in pl, checksum word
   task automatic run_frame(input string tag, input logic [31:0] hdr, input logic [31:0] ck,
                            input int gap_max, input logic [2:0] exp_code);
      send(SYNC);
      chk_val({tag, "_sync_done"}, 32'(frame_done), 32'd0);
      gap(gap_max);
      send(hdr);
      chk_val({tag, "_type"}, 32'(pay_type), 32'(hdr[31:24]));
      chk_val({tag, "_hdr_pv"}, 32'(pay_valid), 32'd0);
      for (int i = 0; i < pl.size(); i++) begin
         gap(gap_max);
         send(pl[i]);
         chk_val($sformatf("%s_pv%0d", tag, i), 32'(pay_valid), 32'd1);
         chk_val($sformatf("%s_pd%0d", tag, i), pay_data, pl[i]);
         chk_val($sformatf("%s_sof%0d", tag, i), 32'(pay_sof), 32'(i == 0));
         chk_val($sformatf("%s_eof%0d", tag, i), 32'(pay_eof), 32'(i == pl.size() - 1));
      end
      gap(gap_max);
      send(ck);
      if (exp_code == 3'd0) exp_ok++; else exp_err++;
      chk_val({tag, "_done"}, 32'(frame_done), 32'd1);
      chk_val({tag, "_ck_pv"}, 32'(pay_valid), 32'd0);
      chk_val({tag, "_ok"}, 32'(frame_ok), 32'(exp_code == 3'd0));
      chk_val({tag, "_code"}, 32'(err_code), 32'(exp_code));
      chk_counters(tag);
   endtask

   initial begin
      int n;
      logic saw_eof;

      // reset state
      idle(3);
      chk_val("rst_pv", 32'(pay_valid), 32'd0);
      chk_val("rst_done", 32'(frame_done), 32'd0);
      chk_val("rst_pd", pay_data, 32'd0);
      chk_val("rst_type", 32'(pay_type), 32'd0);
      chk_val("rst_code", 32'(err_code), 32'd0);
      chk_counters("rst");
      cfg_rst_n = 1'b1;
      idle(2);

      // noise then good frame
      send(32'h1234_5678);
      chk_val("noise_pv", 32'(pay_valid), 32'd0);
      chk_val("noise_done", 32'(frame_done), 32'd0);
      pl = '{32'd1, 32'd2, 32'd3};
      run_frame("good", 32'h0501_0003, 32'h0501_0009, 0, 3'd0);
      idle(1);
      chk_val("good_type_held", 32'(pay_type), 32'h05);

      // same frame, bad checksum
      run_frame("badck", 32'h0501_0003, 32'h0501_0008, 0, 3'd2);

      // zero length
      pl = {};
      run_frame("zero", 32'h0002_0000, 32'h0002_0000, 0, 3'd0);

      // oversize header, error one cycle after header
      send(SYNC);
      send(32'h0003_0041);
      exp_err++;
      chk_val("len_done", 32'(frame_done), 32'd1);
      chk_val("len_code", 32'(err_code), 32'd1);
      chk_val("len_ok", 32'(frame_ok), 32'd0);
      chk_counters("len");
      send(32'd7);
      chk_val("len_hunt_pv", 32'(pay_valid), 32'd0);

      // timeout after two of four payload words
      send(SYNC);
      send(32'h0304_0004);
      send(32'h0000_000A);
      chk_val("to_pd0", pay_data, 32'h0000_000A);
      send(32'h0000_000B);
      chk_val("to_pd1", pay_data, 32'h0000_000B);
      n = 0;
      saw_eof = 1'b0;
      while (n < 1100 && !frame_done) begin
         @(posedge clk_20m);
         #1;
         n++;
         if (pay_eof) saw_eof = 1'b1;
      end
      exp_err++;
      chk_val("to_cycles", 32'(n), 32'd1023);
      chk_val("to_done", 32'(frame_done), 32'd1);
      chk_val("to_code", 32'(err_code), 32'd4);
      chk_val("to_ok", 32'(frame_ok), 32'd0);
      chk_val("to_eof", 32'(saw_eof), 32'd0);
      chk_counters("to");
      idle(1);
      chk_val("to_pulse", 32'(frame_done), 32'd0);

      pl = '{32'h0000_0005};
      run_frame("after_to", 32'h0405_0001, 32'h0405_0006, 0, 3'd0);

      // back-to-back frames, one payload word equal to the sync word
      pl = '{SYNC, 32'h0000_0001};
      run_frame("b2b_a", 32'h0106_0002, 32'hEC96_1472, 0, 3'd0);
      pl = '{32'hFFFF_FFFF};
      run_frame("b2b_b", 32'h0107_0001, 32'h0107_0000, 0, 3'd0);
      pl = '{32'h1000_0000, 32'h2000_0000};
      run_frame("gapped", 32'h0208_0002, 32'h3208_0002, 20, 3'd0);

      // reset in the middle of a frame
      send(SYNC);
      send(32'h0909_0005);
      send(32'h0000_0077);
      chk_val("mid_pv_before", 32'(pay_valid), 32'd1);
      cfg_rst_n = 1'b0;
      #1;
      chk_val("mid_pv", 32'(pay_valid), 32'd0);
      chk_val("mid_type", 32'(pay_type), 32'd0);
      exp_ok = 0;
      exp_err = 0;
      chk_counters("mid");
      idle(2);
      chk_val("mid_done", 32'(frame_done), 32'd0);
      cfg_rst_n = 1'b1;
      idle(1);

      // sequence numbers FE, FF, 00, 02, 03
      pl = '{32'h0000_0010};
      run_frame("seq_fe", 32'h07FE_0001, 32'h07FE_0011, 0, 3'd0);
      run_frame("seq_ff", 32'h07FF_0001, 32'h07FF_0011, 0, 3'd0);
      run_frame("seq_00", 32'h0700_0001, 32'h0700_0011, 0, 3'd0);
`ifdef UPP_SEQ_CHECK_EN
      run_frame("seq_02", 32'h0702_0001, 32'h0702_0011, 0, 3'd3);
`else
      run_frame("seq_02", 32'h0702_0001, 32'h0702_0011, 0, 3'd0);
`endif
      run_frame("seq_03", 32'h0703_0001, 32'h0703_0011, 0, 3'd0);

      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
